// File: rtl/tri_point_test_pipe.sv
// -----------------------------------------------------------------------------
// tri_point_test_pipe
//
// Three-stage pipelined point-in-triangle tester. Each accepted query (a point,
// three vertices and an opaque tag) is classified with three signed edge
// functions. Results leave in input order, one per cycle, behind a
// valid/ready handshake. Either vertex winding is accepted.
//
// Stage 1: sign-extended coordinate differences (W+1 bits).
// Stage 2: the cross-product terms (2W+2 bits).
// Stage 3: edge functions (2W+3 bits) reduced to the result flags.
//
// Ports
//   CLK, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   query handshake (in_ready is combinational)
//   pt_x, pt_y            query point, signed
//   v1_x .. v3_y          triangle vertices, signed
//   in_tag                opaque tag, echoed on out_tag
//   out_valid / out_ready result handshake
//   out_inside            point inside (edge points count when INCLUSIVE=1)
//   out_on_edge           point lies on an edge of a non-degenerate triangle
//   out_degen             triangle has zero area
//   out_tag               tag of the query this result belongs to
//   cnt_clr               synchronous clear of both statistics counters
//   hit_count             delivered results with out_inside=1 (saturating)
//   test_count            delivered results (saturating)
// -----------------------------------------------------------------------------
module tri_point_test_pipe #(
    parameter int W         = 11,
    parameter int TAG_W     = 4,
    parameter bit INCLUSIVE = 1'b1,
    parameter int COUNT_W   = 16
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] pt_x,
    input  logic signed [W-1:0] pt_y,
    input  logic signed [W-1:0] v1_x,
    input  logic signed [W-1:0] v1_y,
    input  logic signed [W-1:0] v2_x,
    input  logic signed [W-1:0] v2_y,
    input  logic signed [W-1:0] v3_x,
    input  logic signed [W-1:0] v3_y,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_inside,
    output logic                out_on_edge,
    output logic                out_degen,
    output logic [TAG_W-1:0]    out_tag,
    input  logic                cnt_clr,
    output logic [COUNT_W-1:0]  hit_count,
    output logic [COUNT_W-1:0]  test_count
);

    localparam int DW = W + 1;      // difference width
    localparam int PW = 2 * W + 2;  // product width
    localparam int EW = 2 * W + 3;  // edge-function width, never truncated

    typedef logic signed [DW-1:0] diff_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [EW-1:0] edge_t;

    // Whole pipeline moves together; it only freezes when a result is waiting.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Vertices as arrays so edge i runs from vertex i to vertex (i+1)%3.
    logic signed [W-1:0] vx [3];
    logic signed [W-1:0] vy [3];

    always_comb begin
        vx[0] = v1_x;  vy[0] = v1_y;
        vx[1] = v2_x;  vy[1] = v2_y;
        vx[2] = v3_x;  vy[2] = v3_y;
    end

    // ---------------------------------------------------------------- stage 1
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    diff_t            s1_ex [3];   // bx - ax
    diff_t            s1_ey [3];   // by - ay
    diff_t            s1_px [3];   // px - ax
    diff_t            s1_py [3];   // py - ay
    diff_t            s1_ax;       // v3x - v1x, for the area term
    diff_t            s1_ay;       // v3y - v1y

    always_ff @(posedge CLK) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: datapath registers have no reset; the valid bits alone decide
    // whether their contents are ever observed.
    always_ff @(posedge CLK) begin
        if (en) begin
            s1_tag <= in_tag;
            for (int i = 0; i < 3; i++) begin
                s1_ex[i] <= DW'(vx[(i + 1) % 3]) - DW'(vx[i]);
                s1_ey[i] <= DW'(vy[(i + 1) % 3]) - DW'(vy[i]);
                s1_px[i] <= DW'(pt_x) - DW'(vx[i]);
                s1_py[i] <= DW'(pt_y) - DW'(vy[i]);
            end
            s1_ax <= DW'(v3_x) - DW'(v1_x);
            s1_ay <= DW'(v3_y) - DW'(v1_y);
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic             s2_valid;
    logic [TAG_W-1:0] s2_tag;
    prod_t            s2_ma [3];   // (bx-ax)*(py-ay)
    prod_t            s2_mb [3];   // (by-ay)*(px-ax)
    prod_t            s2_aa;       // area terms, edge (v1,v2) with p = v3
    prod_t            s2_ab;

    always_ff @(posedge CLK) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            s2_tag <= s1_tag;
            for (int i = 0; i < 3; i++) begin
                s2_ma[i] <= PW'(s1_ex[i]) * PW'(s1_py[i]);
                s2_mb[i] <= PW'(s1_ey[i]) * PW'(s1_px[i]);
            end
            s2_aa <= PW'(s1_ex[0]) * PW'(s1_ay);
            s2_ab <= PW'(s1_ey[0]) * PW'(s1_ax);
        end
    end

    // ---------------------------------------------------------------- stage 3
    edge_t e [3];
    edge_t area2;
    logic  all_nonneg, all_nonpos, all_pos, all_neg, any_zero;
    logic  degen, inside_c, on_edge_c;

    always_comb begin
        all_nonneg = 1'b1;
        all_nonpos = 1'b1;
        all_pos    = 1'b1;
        all_neg    = 1'b1;
        any_zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e[i]       = EW'(s2_ma[i]) - EW'(s2_mb[i]);
            all_nonneg = all_nonneg & ~e[i][EW-1];
            all_nonpos = all_nonpos & (e[i][EW-1] | (e[i] == '0));
            all_pos    = all_pos & ~e[i][EW-1] & (e[i] != '0);
            all_neg    = all_neg & e[i][EW-1];
            any_zero   = any_zero | (e[i] == '0);
        end
        area2     = EW'(s2_aa) - EW'(s2_ab);
        degen     = (area2 == '0);
        on_edge_c = ~degen & any_zero & (all_nonneg | all_nonpos);
        inside_c  = ~degen & (INCLUSIVE ? (all_nonneg | all_nonpos)
                                        : (all_pos | all_neg));
    end

    // Output register; en = 0 only while a result waits, so it holds stable.
    always_ff @(posedge CLK) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_inside  <= 1'b0;
            out_on_edge <= 1'b0;
            out_degen   <= 1'b0;
            out_tag     <= '0;
        end else if (en) begin
            out_valid   <= s2_valid;
            out_inside  <= inside_c;
            out_on_edge <= on_edge_c;
            out_degen   <= degen;
            out_tag     <= s2_tag;
        end
    end

    // ------------------------------------------------------------- statistics
    // Clear wins over a same-cycle delivery; both counters stick at all-ones.
    always_ff @(posedge CLK) begin
        if (rst || cnt_clr) begin
            hit_count  <= '0;
            test_count <= '0;
        end else if (out_valid && out_ready) begin
            if (test_count != '1) begin
                test_count <= test_count + COUNT_W'(1);
            end
            if (out_inside && (hit_count != '1)) begin
                hit_count <= hit_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tri_point_test_pipe.sv
// -----------------------------------------------------------------------------
// Bench for tri_point_test_pipe. Two instances share every input: the default
// build (INCLUSIVE=1, 16-bit counters) and a strict build with 4-bit counters.
// A monitor on the falling edge scores every delivered result against a
// queue of expectations computed from the triangle edge equations, and
// tracks the statistics counters.
// -----------------------------------------------------------------------------
module tb_tri_point_test_pipe;

    localparam int W     = 11;
    localparam int TAG_W = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b1;
    logic                cnt_clr = 1'b0;
    logic signed [W-1:0] pt_x, pt_y, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic [TAG_W-1:0]    in_tag;

    logic             in_ready, out_valid, out_inside, out_on_edge, out_degen;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      hit_count, test_count;

    logic             in_ready_b, out_valid_b, out_inside_b, out_on_edge_b, out_degen_b;
    logic [TAG_W-1:0] out_tag_b;
    logic [3:0]       hit_count_b, test_count_b;

    tri_point_test_pipe #(.W(W), .TAG_W(TAG_W), .INCLUSIVE(1'b1), .COUNT_W(16)) dut (
        .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pt_x(pt_x), .pt_y(pt_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
        .v3_x(v3_x), .v3_y(v3_y), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_inside(out_inside), .out_on_edge(out_on_edge),
        .out_degen(out_degen), .out_tag(out_tag), .cnt_clr(cnt_clr),
        .hit_count(hit_count), .test_count(test_count)
    );

    tri_point_test_pipe #(.W(W), .TAG_W(TAG_W), .INCLUSIVE(1'b0), .COUNT_W(4)) dut_b (
        .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .pt_x(pt_x), .pt_y(pt_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
        .v3_x(v3_x), .v3_y(v3_y), .in_tag(in_tag), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_inside(out_inside_b), .out_on_edge(out_on_edge_b),
        .out_degen(out_degen_b), .out_tag(out_tag_b), .cnt_clr(cnt_clr),
        .hit_count(hit_count_b), .test_count(test_count_b)
    );

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    typedef struct {
        logic [TAG_W-1:0] tag;
        bit               ins_incl;
        bit               ins_strict;
        bit               on_edge;
        bit               degen;
        bit               lat_chk;
        bit               seen;
        int               push_cyc;
    } exp_t;

    function automatic longint edge_fn(input longint ax, input longint ay,
                                       input longint bx, input longint by,
                                       input longint px, input longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic exp_t model(input int px, input int py, input int x1, input int y1,
                                   input int x2, input int y2, input int x3, input int y3);
        exp_t   r;
        longint e [3];
        longint area;
        bit     nonneg, nonpos, anyz, strict;
        e[0]   = edge_fn(x1, y1, x2, y2, px, py);
        e[1]   = edge_fn(x2, y2, x3, y3, px, py);
        e[2]   = edge_fn(x3, y3, x1, y1, px, py);
        area   = edge_fn(x1, y1, x2, y2, x3, y3);
        nonneg = (e[0] >= 0) && (e[1] >= 0) && (e[2] >= 0);
        nonpos = (e[0] <= 0) && (e[1] <= 0) && (e[2] <= 0);
        anyz   = (e[0] == 0) || (e[1] == 0) || (e[2] == 0);
        strict = ((e[0] > 0) && (e[1] > 0) && (e[2] > 0)) ||
                 ((e[0] < 0) && (e[1] < 0) && (e[2] < 0));
        r.tag        = '0;
        r.degen      = (area == 0);
        r.ins_incl   = !r.degen && (nonneg || nonpos);
        r.ins_strict = !r.degen && strict;
        r.on_edge    = !r.degen && anyz && (nonneg || nonpos);
        r.lat_chk    = 1'b0;
        r.seen       = 1'b0;
        r.push_cyc   = 0;
        return r;
    endfunction

    exp_t q[$];
    int   cyc    = 0;
    bit   lat_en = 1'b0;
    int   m_test = 0, m_hit = 0, m_test_b = 0, m_hit_b = 0;

    // Monitor: everything it reads was driven after the previous rising edge.
    always @(negedge CLK) begin
        exp_t x;
        cyc++;
        if (rst) begin
            q.delete();
            m_test = 0; m_hit = 0; m_test_b = 0; m_hit_b = 0;
        end else begin
            check("test_count", test_count, m_test);
            check("hit_count", hit_count, m_hit);
            check("test_count_b", test_count_b, m_test_b);
            check("hit_count_b", hit_count_b, m_hit_b);
            check("in_ready", in_ready, !out_valid || out_ready);
            check("in_ready_b", in_ready_b, !out_valid_b || out_ready);
            if (q.size() == 0) begin
                check("spurious_valid", out_valid, 0);
                check("spurious_valid_b", out_valid_b, 0);
            end else if (out_valid) begin
                check("out_valid_b", out_valid_b, 1);
                check("tag", out_tag, q[0].tag);
                check("inside", out_inside, q[0].ins_incl);
                check("on_edge", out_on_edge, q[0].on_edge);
                check("degen", out_degen, q[0].degen);
                check("tag_b", out_tag_b, q[0].tag);
                check("inside_b", out_inside_b, q[0].ins_strict);
                check("on_edge_b", out_on_edge_b, q[0].on_edge);
                check("degen_b", out_degen_b, q[0].degen);
                if (!q[0].seen) begin
                    if (q[0].lat_chk) check("latency", cyc - q[0].push_cyc, 3);
                    q[0].seen = 1'b1;
                end
                if (out_ready) begin
                    x = q.pop_front();
                    if (m_test < 65535) m_test++;
                    if (x.ins_incl && m_hit < 65535) m_hit++;
                    if (m_test_b < 15) m_test_b++;
                    if (x.ins_strict && m_hit_b < 15) m_hit_b++;
                end
            end
            if (cnt_clr) begin
                m_test = 0; m_hit = 0; m_test_b = 0; m_hit_b = 0;
            end
            if (in_valid && in_ready) begin
                x = model(int'(pt_x), int'(pt_y), int'(v1_x), int'(v1_y),
                          int'(v2_x), int'(v2_y), int'(v3_x), int'(v3_y));
                x.tag      = in_tag;
                x.lat_chk  = lat_en;
                x.push_cyc = cyc;
                q.push_back(x);
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random back-pressure, 2 = stalled.
    int ready_mode = 0;
    always @(posedge CLK) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // -------------------------------------------------------------- drivers
    task automatic set_query(input int tag, input int px, input int py, input int x1,
                             input int y1, input int x2, input int y2, input int x3,
                             input int y3);
        in_tag = TAG_W'(tag);
        pt_x = W'(px);  pt_y = W'(py);
        v1_x = W'(x1);  v1_y = W'(y1);
        v2_x = W'(x2);  v2_y = W'(y2);
        v3_x = W'(x3);  v3_y = W'(y3);
    endtask

    task automatic send(input int tag, input int px, input int py, input int x1,
                        input int y1, input int x2, input int y2, input int x3,
                        input int y3);
        bit ok;
        ok = 1'b0;
        set_query(tag, px, py, x1, y1, x2, y2, x3, y3);
        in_valid = 1'b1;
        for (int b = 0; b < 200 && !ok; b++) begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((q.size() != 0 || out_valid) && b < 300) begin
            @(posedge CLK);
            #1;
            b++;
        end
        check("drain_done", (b < 300), 1);
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge CLK);
        #1;
        cnt_clr = 1'b0;
    endtask

    function automatic int rnd(input int span);
        return int'($urandom_range(2 * span)) - span;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- sequence
    initial begin
        set_query(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_inside", out_inside, 0);
        check("rst_on_edge", out_on_edge, 0);
        check("rst_degen", out_degen, 0);
        check("rst_tag", out_tag, 0);
        check("rst_hit", hit_count, 0);
        check("rst_test", test_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed shapes, unstalled, latency checked
        lat_en = 1'b1;
        send(1, 3, 3, 0, 0, 10, 0, 0, 10);
        send(2, 3, 3, 15, 15, 30, 0, 15, 0);
        send(3, 3, 3, 15, 15, 15, 0, 30, 0);
        send(4, 5, 0, 0, 0, 10, 0, 0, 10);
        send(5, 5, 5, 0, 0, 5, 5, 10, 10);
        send(6, 0, 0, -1024, -1024, 1023, -1024, -1024, 1023);
        send(7, 0, 0, 0, 0, 0, 10, 10, 0);
        send(8, 10, 10, 0, 0, 10, 0, 0, 10);
        drain();

        // Six back-to-back queries through a downstream stall
        lat_en = 1'b0;
        pulse_clr();
        fork
            begin
                for (int t = 0; t < 6; t++) send(t, 2 + t % 3, 1 + t % 2, 0, 0, 10, 0, 0, 10);
            end
            begin
                repeat (2) @(posedge CLK);
                #1 ready_mode = 2;
                repeat (3) @(posedge CLK);
                #1;
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge CLK);
                #1 ready_mode = 0;
            end
        join
        drain();
        check("burst_test_count", test_count, 6);
        check("burst_test_count_b", test_count_b, 6);

        // Counter saturation on the 4-bit build
        lat_en = 1'b1;
        pulse_clr();
        for (int i = 0; i < 20; i++) send(i % 16, 1 + i % 5, 1 + i % 3, 0, 0, 10, 0, 0, 10);
        drain();
        check("sat_hit_b", hit_count_b, 15);
        check("sat_test_b", test_count_b, 15);
        check("sat_hit", hit_count, 20);
        check("sat_test", test_count, 20);

        // Clear coinciding with an output transfer
        send(9, 3, 3, 0, 0, 10, 0, 0, 10);
        for (int b = 0; b < 20 && !out_valid; b++) begin
            @(posedge CLK);
            #1;
        end
        check("clr_wait_valid", out_valid, 1);
        pulse_clr();
        check("clr_hit", hit_count, 0);
        check("clr_test", test_count, 0);
        check("clr_hit_b", hit_count_b, 0);
        check("clr_test_b", test_count_b, 0);

        // Reset with three queries in flight
        lat_en = 1'b0;
        set_query(10, 3, 3, 0, 0, 10, 0, 0, 10);
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_tag = 4'd11;
        @(posedge CLK);
        #1 in_tag = 4'd12;
        rst = 1'b1;
        @(posedge CLK);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_test", test_count, 0);
        repeat (6) @(posedge CLK);
        #1;
        check("mid_rst_quiet", out_valid, 0);

        // Randomised traffic under random back-pressure
        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            int s;
            s = ($urandom_range(1) == 0) ? 12 : 1023;
            send(int'($urandom_range(15)), rnd(s), rnd(s), rnd(s), rnd(s),
                 rnd(s), rnd(s), rnd(s), rnd(s));
        end
        drain();
        ready_mode = 0;
        @(posedge CLK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
